// File: rtl/inning_tracker_pkg.sv
// inning_tracker_pkg: shared FSM encoding, winner codes, 7-seg glyphs and popcount helper.
package inning_tracker_pkg;

    typedef enum logic [1:0] {
        ST_TOP    = 2'd0,
        ST_BOTTOM = 2'd1,
        ST_FINAL  = 2'd2
    } state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_AWAY = 2'b01;
    localparam logic [1:0] WINNER_HOME = 2'b10;
    localparam logic [1:0] WINNER_TIE  = 2'b11;

    // Active-high segments {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/inning_seg7_dec.sv
// inning_seg7_dec: inning value to 7-seg glyph, forced to 'F' once the game is final.
module inning_seg7_dec
    import inning_tracker_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       final_i,
    output logic [6:0] seg_o
);

    assign seg_o = final_i ? SEG_GLYPH[15] : SEG_GLYPH[value_i];

endmodule

// File: rtl/inning_tracker.sv
// inning_tracker: inning/half sequencing, per-team saturating run totals and game-end decisions.
module inning_tracker
    import inning_tracker_pkg::*;
#(
    parameter int LAST_INNING = 9,
    parameter int MAX_INNING  = 12,
    parameter int RUN_W       = 6
) (
    input  logic             clk_divided,
    input  logic             reset_n,
    input  logic             change_pulse,
    input  logic [3:0]       add_to_score_pulse,
    output logic [3:0]       inning,
    output logic             half,
    output logic [RUN_W-1:0] runs_away,
    output logic [RUN_W-1:0] runs_home,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic             play_enable,
    output logic [6:0]       inning_seg7
);

    localparam logic [3:0] LAST = 4'(LAST_INNING);
    localparam logic [3:0] MAX  = 4'(MAX_INNING);
    localparam int         SW   = RUN_W + 1;

    state_e           state_q, state_d;
    logic [3:0]       inning_q, inning_d;
    logic             half_q, half_d;
    logic [RUN_W-1:0] away_q, away_d, home_q, home_d;
    logic [1:0]       winner_q, winner_d;
    logic             game_over_q, play_enable_q;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       n;
    logic [RUN_W:0]   away_sum, home_sum;
    logic [RUN_W-1:0] away_new, home_new;

    assign n        = popcount4(add_to_score_pulse);
    assign away_sum = {1'b0, away_q} + SW'(n);
    assign home_sum = {1'b0, home_q} + SW'(n);
    assign away_new = away_sum[RUN_W] ? '1 : away_sum[RUN_W-1:0];
    assign home_new = home_sum[RUN_W] ? '1 : home_sum[RUN_W-1:0];

    // Runs are credited before the transition decision so same-cycle score+change uses new totals.
    always_comb begin
        state_d  = state_q;
        inning_d = inning_q;
        half_d   = half_q;
        away_d   = away_q;
        home_d   = home_q;
        winner_d = winner_q;
        if (state_q == ST_TOP) begin
            away_d = away_new;
            if (change_pulse) begin
                if (inning_q >= LAST && home_q > away_new) begin
                    state_d  = ST_FINAL;
                    winner_d = WINNER_HOME;
                end else begin
                    state_d = ST_BOTTOM;
                    half_d  = 1'b1;
                end
            end
        end else if (state_q == ST_BOTTOM) begin
            home_d = home_new;
            if (inning_q >= LAST && home_new > away_q) begin
                state_d  = ST_FINAL;
                winner_d = WINNER_HOME;
            end else if (change_pulse) begin
                if (inning_q < LAST || (away_q == home_new && inning_q < MAX)) begin
                    state_d  = ST_TOP;
                    half_d   = 1'b0;
                    inning_d = inning_q + 4'd1;
                end else begin
                    state_d  = ST_FINAL;
                    winner_d = (away_q > home_new) ? WINNER_AWAY : WINNER_TIE;
                end
            end
        end
    end

    inning_seg7_dec u_seg7 (
        .value_i (inning_d),
        .final_i (state_d == ST_FINAL),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk_divided or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_TOP;
            inning_q      <= 4'd1;
            half_q        <= 1'b0;
            away_q        <= '0;
            home_q        <= '0;
            winner_q      <= WINNER_NONE;
            game_over_q   <= 1'b0;
            play_enable_q <= 1'b1;
            seg_q         <= SEG_GLYPH[1];
        end else begin
            state_q       <= state_d;
            inning_q      <= inning_d;
            half_q        <= half_d;
            away_q        <= away_d;
            home_q        <= home_d;
            winner_q      <= winner_d;
            game_over_q   <= (state_d == ST_FINAL);
            play_enable_q <= (state_d != ST_FINAL);
            seg_q         <= seg_d;
        end
    end

    assign inning      = inning_q;
    assign half        = half_q;
    assign runs_away   = away_q;
    assign runs_home   = home_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign play_enable = play_enable_q;
    assign inning_seg7 = seg_q;

endmodule

// File: tb/tb_inning_tracker.sv
// tb_inning_tracker: directed scoreboard bench; stimulus pushes expectations, a monitor pops and compares.
module tb_inning_tracker;

    logic       clk_divided = 1'b0;
    logic       reset_n = 1'b0;
    logic       change_pulse = 1'b0;
    logic [3:0] add_to_score_pulse = 4'b0;
    logic [3:0] inning;
    logic       half;
    logic [5:0] runs_away, runs_home;
    logic       game_over;
    logic [1:0] winner;
    logic       play_enable;
    logic [6:0] inning_seg7;

    typedef struct {
        string       nm;
        logic [27:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    inning_tracker dut (
        .clk_divided        (clk_divided),
        .reset_n            (reset_n),
        .change_pulse       (change_pulse),
        .add_to_score_pulse (add_to_score_pulse),
        .inning             (inning),
        .half               (half),
        .runs_away          (runs_away),
        .runs_home          (runs_home),
        .game_over          (game_over),
        .winner             (winner),
        .play_enable        (play_enable),
        .inning_seg7        (inning_seg7)
    );

    always #5 clk_divided = ~clk_divided;

    // Expected vector: {inning, half, away, home, game_over, winner, play_enable, seg}.
    function automatic logic [27:0] pack(input int inn, input int hf, input int aw, input int hm, input int win);
        logic over;
        over = (win != 0);
        return {4'(inn), 1'(hf), 6'(aw), 6'(hm), over, 2'(win), ~over, over ? glyph[15] : glyph[inn]};
    endfunction

    function automatic logic [27:0] actual();
        return {inning, half, runs_away, runs_home, game_over, winner, play_enable, inning_seg7};
    endfunction

    task automatic cmp(input string nm, input logic [27:0] act, input logic [27:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk_divided) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, actual(), e.v);
        end
    end

    task automatic step(input logic chg, input logic [3:0] sc, input string nm,
                        input int inn, input int hf, input int aw, input int hm, input int win);
        @(negedge clk_divided);
        change_pulse = chg;
        add_to_score_pulse = sc;
        q.push_back('{nm, pack(inn, hf, aw, hm, win)});
    endtask

    task automatic rst_check(input string nm);
        @(negedge clk_divided);
        reset_n = 1'b0;
        change_pulse = 1'b0;
        add_to_score_pulse = 4'b0;
        q.push_back('{nm, pack(1, 0, 0, 0, 0)});
        @(negedge clk_divided);
        reset_n = 1'b1;
    endtask

    initial begin
        rst_check("reset");
        // 1: runs in top 1, then change to bottom 1
        step(0, 4'b0001, "t1 run1", 1, 0, 1, 0, 0);
        step(0, 4'b0011, "t1 run3", 1, 0, 3, 0, 0);
        step(1, 4'b0000, "t1 change", 1, 1, 3, 0, 0);
        // 2: home leads after top 9 -> bottom 9 skipped
        rst_check("t2 reset");
        step(0, 4'b0001, "t2 away1", 1, 0, 1, 0, 0);
        step(1, 4'b0000, "t2 chg1", 1, 1, 1, 0, 0);
        step(0, 4'b0011, "t2 home2", 1, 1, 1, 2, 0);
        step(1, 4'b0000, "t2 top2", 2, 0, 1, 2, 0);
        for (int i = 2; i < 9; i++) begin
            step(1, 4'b0000, "t2 bot", i, 1, 1, 2, 0);
            step(1, 4'b0000, "t2 top", i + 1, 0, 1, 2, 0);
        end
        step(1, 4'b0000, "t2 skip bottom9", 9, 0, 1, 2, 2);
        step(1, 4'b1111, "t2 hold1", 9, 0, 1, 2, 2);
        step(0, 4'b0001, "t2 hold2", 9, 0, 1, 2, 2);
        // 3: walk-off in bottom 9 without change pulse
        rst_check("t3 reset");
        step(0, 4'b1111, "t3 away4", 1, 0, 4, 0, 0);
        step(1, 4'b0000, "t3 chg1", 1, 1, 4, 0, 0);
        step(0, 4'b0011, "t3 home2", 1, 1, 4, 2, 0);
        step(1, 4'b0000, "t3 top2", 2, 0, 4, 2, 0);
        for (int i = 2; i < 9; i++) begin
            step(1, 4'b0000, "t3 bot", i, 1, 4, 2, 0);
            step(1, 4'b0000, "t3 top", i + 1, 0, 4, 2, 0);
        end
        step(1, 4'b0000, "t3 bottom9", 9, 1, 4, 2, 0);
        step(0, 4'b0111, "t3 walkoff", 9, 1, 4, 5, 2);
        step(1, 4'b0000, "t3 hold", 9, 1, 4, 5, 2);
        // 4: tie through extra innings to the limit
        rst_check("t4 reset");
        step(0, 4'b0111, "t4 away3", 1, 0, 3, 0, 0);
        step(1, 4'b0000, "t4 chg1", 1, 1, 3, 0, 0);
        step(0, 4'b0111, "t4 home3", 1, 1, 3, 3, 0);
        step(1, 4'b0000, "t4 top2", 2, 0, 3, 3, 0);
        for (int i = 2; i <= 12; i++) begin
            step(1, 4'b0000, "t4 bot", i, 1, 3, 3, 0);
            if (i < 12)
                step(1, 4'b0000, (i == 9) ? "t4 extra10" : "t4 top", i + 1, 0, 3, 3, 0);
            else
                step(1, 4'b0000, "t4 tie final", 12, 1, 3, 3, 3);
        end
        step(1, 4'b0001, "t4 hold", 12, 1, 3, 3, 3);
        // 5: same-cycle score and change in bottom 9, tie 0-0
        rst_check("t5 reset");
        for (int i = 1; i <= 9; i++) begin
            step(1, 4'b0000, "t5 bot", i, 1, 0, 0, 0);
            if (i < 9) step(1, 4'b0000, "t5 top", i + 1, 0, 0, 0, 0);
        end
        step(1, 4'b1111, "t5 score+change", 9, 1, 0, 4, 2);
        // 6: saturation, then async reset mid-bottom
        rst_check("t6 reset");
        for (int k = 1; k <= 16; k++)
            step(0, 4'b1111, "t6 sat", 1, 0, (4 * k > 63) ? 63 : 4 * k, 0, 0);
        step(1, 4'b0000, "t6 chg", 1, 1, 63, 0, 0);
        step(0, 4'b0001, "t6 home1", 1, 1, 63, 1, 0);
        @(negedge clk_divided);
        change_pulse = 1'b0;
        add_to_score_pulse = 4'b0;
        #2;
        reset_n = 1'b0;
        #1;
        cmp("t6 async reset", actual(), pack(1, 0, 0, 0, 0));
        @(negedge clk_divided);
        reset_n = 1'b1;
        rst_check("t6 reset again");
        step(0, 4'b0000, "t6 idle", 1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_divided);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
